// File: rtl/snake_frame_sequencer.sv
// snake_frame_sequencer: walks the segment store once per frame and publishes a tile occupancy map
// atomically, along with head tile, self-hit and sticky range-error flags.
module snake_frame_sequencer #(
    parameter int MAX_SEGS = 100,
    parameter int GRID_W   = 10,
    parameter int GRID_H   = 10,
    parameter int COORD_W  = 32,
    parameter int ADDR_W   = $clog2(MAX_SEGS)
) (
    input  logic                       clk25,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic                       game_done,
    output logic                       seg_rd,
    output logic [ADDR_W-1:0]          seg_addr,
    input  logic [COORD_W-1:0]         seg_x,
    input  logic [COORD_W-1:0]         seg_y,
    output logic [GRID_W*GRID_H-1:0]   occ_map,
    output logic [ADDR_W-1:0]          head_tile,
    output logic                       head_valid,
    output logic                       self_hit,
    output logic                       range_err,
    output logic                       busy,
    output logic                       frame_swap
);
    localparam int NT = GRID_W * GRID_H;
    localparam int TW = $clog2(NT);

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN, PUBLISH} state_t;
    state_t state, state_nx;

    logic [ADDR_W:0]   nxt;
    logic              ret_v;
    logic [ADDR_W-1:0] ret_idx;
    logic [NT-1:0]     wmap;
    logic              whit, whv;
    logic [ADDR_W-1:0] whead;
    logic              empty, in_range, last, issue;
    logic [TW-1:0]     tile;

    // coordinates are range-checked before tile is used, so the low bits suffice
    assign empty    = &seg_x || &seg_y;
    assign in_range = seg_x < COORD_W'(GRID_W) && seg_y < COORD_W'(GRID_H);
    assign tile     = seg_y[TW-1:0] * TW'(GRID_W) + seg_x[TW-1:0];
    assign last     = ret_v && (empty || ret_idx == ADDR_W'(MAX_SEGS - 1));
    assign issue    = nxt < (ADDR_W + 1)'(MAX_SEGS) && !(ret_v && empty);

    always_ff @(posedge clk25 or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = frame_start && !game_done ? CLEAR : IDLE;
            CLEAR:   state_nx = SCAN;
            SCAN:    state_nx = last ? PUBLISH : SCAN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            seg_rd     <= 1'b0;
            seg_addr   <= '0;
            nxt        <= '0;
            ret_v      <= 1'b0;
            ret_idx    <= '0;
            wmap       <= '0;
            whit       <= 1'b0;
            whv        <= 1'b0;
            whead      <= '0;
            occ_map    <= '0;
            head_tile  <= '0;
            head_valid <= 1'b0;
            self_hit   <= 1'b0;
            range_err  <= 1'b0;
            busy       <= 1'b0;
            frame_swap <= 1'b0;
        end else begin
            busy       <= state_nx != IDLE;
            frame_swap <= state == PUBLISH;
            ret_v      <= seg_rd;
            ret_idx    <= seg_addr;
            if (state == CLEAR) begin
                seg_rd   <= 1'b1;
                seg_addr <= '0;
                nxt      <= (ADDR_W + 1)'(1);
                wmap     <= '0;
                whit     <= 1'b0;
                whv      <= 1'b0;
                whead    <= '0;
            end else if (state == SCAN) begin
                seg_rd <= issue;
                if (issue) begin
                    seg_addr <= nxt[ADDR_W-1:0];
                    nxt      <= nxt + 1'b1;
                end
                if (ret_v && !empty) begin
                    if (!in_range) range_err <= 1'b1;
                    else begin
                        whit       <= whit | wmap[tile];
                        wmap[tile] <= 1'b1;
                        if (ret_idx == '0) begin
                            whv   <= 1'b1;
                            whead <= ADDR_W'(tile);
                        end
                    end
                end
            end else begin
                seg_rd <= 1'b0;
            end
            if (state == PUBLISH) begin
                occ_map    <= wmap;
                self_hit   <= whit;
                head_tile  <= whead;
                head_valid <= whv;
            end
        end
    end
endmodule

// File: doc/snake_frame_sequencer.md
# snake_frame_sequencer

Per-frame scheduler that turns the packed snake segment list into a tile occupancy map for the VGA pixel path. On each frame-end pulse it walks the segment store one entry per cycle through a registered read port and stops at the first empty (all-ones) entry. It accumulates a working bitmap of the GRID_W×GRID_H board, then publishes it atomically before the next active frame. The pixel path then needs only one bit lookup per tile instead of comparing against every segment per pixel.

## Interface
- MAX_SEGS, 100, segment store depth
- GRID_W, 10, board width in tiles
- GRID_H, 10, board height in tiles
- COORD_W, 32, segment coordinate width; all-ones = empty entry
- ADDR_W, $clog2(MAX_SEGS), segment address width
- clk25  in  1  25 MHz pixel clock; the only clock
- reset  in  1  asynchronous, active-low
- frame_start  in  1  one-cycle pulse (timing generator screenEnd)
- game_done  in  1  when high at frame_start, skip the scan and hold the published map
- seg_rd  out  1  segment read strobe
- seg_addr  out  ADDR_W  segment index
- seg_x  in  COORD_W  tile x of the segment addressed in the previous cycle
- seg_y  in  COORD_W  tile y, same timing as seg_x
- occ_map  out  GRID_W*GRID_H  published occupancy; bit y*GRID_W+x
- head_tile  out  ADDR_W  tile index of segment 0
- head_valid  out  1  segment 0 was non-empty and in range
- self_hit  out  1  at least two segments shared a tile in the published frame
- range_err  out  1  sticky; an in-range check failed since reset
- busy  out  1  scan in progress
- frame_swap  out  1  one-cycle pulse, new map published

## Operation
- States: IDLE, CLEAR, SCAN, PUBLISH.
- IDLE → CLEAR: when frame_start=1 and game_done=0. If game_done=1, stay in IDLE with no reads and no swap.
- CLEAR: zero the working map, working self_hit and working head; set issue index k=0. Go to SCAN.
- SCAN, issue side:
  - seg_rd=1 and seg_addr=k while k<MAX_SEGS and no empty entry has been seen; k increments each cycle.
  - At most one read is issued past the empty entry; that read is harmless.
- SCAN, return side, one cycle behind issue:
  - Empty entry: either coordinate is all ones. Ends the scan.
  - Else if x≥GRID_W or y≥GRID_H (unsigned): skip the entry and set range_err.
  - Else compute t=y*GRID_W+x. If working bit t is already 1, set working self_hit. Then set bit t.
  - If the returned index is 0 and the entry is valid, capture head t.
- SCAN → PUBLISH: on the first empty entry returned, or after entry MAX_SEGS-1 is returned.
- PUBLISH: at the clock edge, load occ_map, self_hit, head_tile and head_valid from working state. Pulse frame_swap in the following cycle. Go to IDLE.
- frame_start while busy=1 is ignored, not queued.
- game_done changing mid-scan has no effect; it is sampled only at frame_start.
- range_err clears only on reset.

## Timing
- All outputs are registered.
- Reset values: occ_map=0, head_tile=0, head_valid=0, self_hit=0, range_err=0, busy=0, frame_swap=0, seg_rd=0, seg_addr=0. State returns to IDLE.
- Reset asserted mid-scan aborts immediately; published outputs go to their reset values.
- Read latency is exactly 1 cycle: seg_x/seg_y are sampled in the cycle after seg_rd.
- Cycle timeline, with frame_start sampled in cycle 0:
  - cycle 1: CLEAR
  - cycle 2+k: SCAN issues address k
  - cycle 3+k: data for address k is evaluated
- Latency from frame_start to the frame_swap cycle:
  - empty entry at index N (N<MAX_SEGS): N+5 cycles
  - full list: MAX_SEGS+4 cycles
- busy is high in cycles 1 through PUBLISH inclusive. It is low in the frame_swap cycle.
- occ_map changes only in the frame_swap cycle; there is never a partial map.
- Worst case is 104 cycles, which fits the vertical blanking interval.

## Test plan
- Reset, then segments (3,4),(3,5),(3,6),empty; frame_start at cycle 0 → reads at addresses 0..4. frame_swap at cycle 8. occ_map bits 43,53,63 set, all others 0. head_tile=43, head_valid=1, self_hit=0.
- Segments (2,2),(2,3),(2,2),empty → bits 22 and 32 set, self_hit=1.
- Segment (10,0) then (1,1),empty → only bit 11 set. head_valid=0, range_err=1, and range_err stays 1 after a clean following frame.
- All 100 entries valid, tiles 0..99 → frame_swap at cycle 104, occ_map all ones, seg_addr reaches 99.
- game_done=1 at frame_start → seg_rd stays 0, no frame_swap, occ_map unchanged. A second frame_start pulse at cycle 5 of an active scan is ignored.
- reset pulled low at cycle 4 of a scan → all outputs go to 0 asynchronously. The next frame_start gives a normal scan.
